// File: rtl/omem_wb_writer_pkg.sv
// Shared widths, FIFO entry layout and FSM encoding for the output-memory Wishbone writer.
package omem_wb_writer_pkg;

  localparam int WB_WIDTH        = 32;
  localparam int ROW_WIDTH       = 3 * WB_WIDTH;
  localparam int OMEM_FIFO_DEPTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BEAT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [WB_WIDTH-1:0]  base;
    logic [ROW_WIDTH-1:0] data;
  } row_entry_t;

  localparam int ENTRY_WIDTH = $bits(row_entry_t);

  // Component k of a row: 0 = X (top word), 1 = Y, 2 = Z (bottom word).
  function automatic logic [WB_WIDTH-1:0] row_component(input logic [ROW_WIDTH-1:0] data,
                                                       input logic [1:0]           k);
    case (k)
      2'd0:    return data[3*WB_WIDTH-1 -: WB_WIDTH];
      2'd1:    return data[2*WB_WIDTH-1 -: WB_WIDTH];
      default: return data[WB_WIDTH-1:0];
    endcase
  endfunction

endpackage

// File: rtl/omem_wb_writer_if.sv
// Wishbone single-write master bus used by the output-memory writer.
interface omem_wb_writer_if;
  import omem_wb_writer_pkg::*;

  logic [WB_WIDTH-1:0] adr;
  logic [WB_WIDTH-1:0] dat;
  logic                we;
  logic                stb;
  logic                cyc;
  logic                ack;

  modport master (output adr, dat, we, stb, cyc, input ack);
  modport slave  (input adr, dat, we, stb, cyc, output ack);

endinterface

// File: rtl/omem_row_fifo.sv
// Synchronous row FIFO with registered full/empty flags and an occupancy count.
module omem_row_fifo
  import omem_wb_writer_pkg::*;
#(
  parameter int WIDTH = ENTRY_WIDTH,
  parameter int DEPTH = OMEM_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: storage is deliberately not reset; validity is tracked by pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/omem_wb_writer.sv
// Buffers 3-component output-memory rows and drains each as three back-to-back Wishbone writes.
module omem_wb_writer
  import omem_wb_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = OMEM_FIFO_DEPTH
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  iWriteEnable,
  input  logic [ROW_WIDTH-1:0]  iAddress,
  input  logic [ROW_WIDTH-1:0]  iData,
  output logic                  oFull,
  output logic                  oOverflow,
  output logic                  oIdle,
  omem_wb_writer_if.master      wb
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  row_entry_t             push_entry;
  row_entry_t             head;
  logic [ENTRY_WIDTH-1:0] fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   pop;
  wb_state_t              state;
  logic [1:0]             k;
  logic                   unused_addr_bits;

  // Only the low word of the row address carries the base; the rest is ignored.
  assign push_entry       = '{base: iAddress[WB_WIDTH-1:0], data: iData};
  assign unused_addr_bits = ^iAddress[ROW_WIDTH-1:WB_WIDTH];
  assign head             = row_entry_t'(fifo_rdata);

  assign pop       = (state == BEAT) && wb.ack && (k == 2'd2);
  assign oFull     = fifo_full;
  assign oIdle     = (fifo_count == '0) && (state == IDLE);

  omem_row_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (iWriteEnable),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      oOverflow <= 1'b0;
    end else if (iWriteEnable && fifo_full) begin
      oOverflow <= 1'b1;
    end
  end

  // The head entry stays put until the final beat, so later beats read it directly.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state  <= IDLE;
      k      <= 2'd0;
      wb.adr <= '0;
      wb.dat <= '0;
      wb.we  <= 1'b0;
      wb.stb <= 1'b0;
      wb.cyc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state  <= BEAT;
            k      <= 2'd0;
            wb.adr <= head.base;
            wb.dat <= row_component(head.data, 2'd0);
            wb.we  <= 1'b1;
            wb.stb <= 1'b1;
            wb.cyc <= 1'b1;
          end
        end
        BEAT: begin
          if (wb.ack) begin
            if (k != 2'd2) begin
              k      <= k + 2'd1;
              wb.adr <= wb.adr + WB_WIDTH'(1);
              wb.dat <= row_component(head.data, k + 2'd1);
            end else begin
              state  <= IDLE;
              k      <= 2'd0;
              wb.we  <= 1'b0;
              wb.stb <= 1'b0;
              wb.cyc <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omem_wb_writer.sv
// Scoreboard bench: accepted rows queue their expected beats; a negedge monitor checks bus beats and flags.
module tb_omem_wb_writer;
  import omem_wb_writer_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 we;
  logic [ROW_WIDTH-1:0] addr;
  logic [ROW_WIDTH-1:0] data;
  logic                 full;
  logic                 ovf;
  logic                 idle;

  always #5 clk = ~clk;

  omem_wb_writer_if bus ();

  omem_wb_writer dut (
    .CLK_I        (clk),
    .RST_I        (rst),
    .iWriteEnable (we),
    .iAddress     (addr),
    .iData        (data),
    .oFull        (full),
    .oOverflow    (ovf),
    .oIdle        (idle),
    .wb           (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rows outstanding, sticky overflow, expected beat stream.
  typedef struct {
    logic [WB_WIDTH-1:0] adr;
    logic [WB_WIDTH-1:0] dat;
  } beat_t;

  beat_t               exp_q[$];
  beat_t               e;
  int                  occ        = 0;
  bit                  m_ovf      = 1'b0;
  int                  beat_idx   = 0;
  int                  beats_seen = 0;
  bit                  accept;
  bit                  prev_hold  = 1'b0;
  logic [WB_WIDTH-1:0] prev_adr, prev_dat;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      occ      = 0;
      m_ovf    = 1'b0;
      beat_idx = 0;
    end else begin
      check("full", full, occ == OMEM_FIFO_DEPTH);
      check("overflow", ovf, m_ovf);
      check("idle", idle, occ == 0);
      check("cyc_we_track_stb", {bus.cyc, bus.we}, {bus.stb, bus.stb});
      if (prev_hold) begin
        check("hold_stb", bus.stb, 1'b1);
        check("hold_adr", bus.adr, prev_adr);
        check("hold_dat", bus.dat, prev_dat);
      end
      accept = we && (occ < OMEM_FIFO_DEPTH);
      if (bus.stb && bus.ack) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: adr 0x%0h dat 0x%0h with nothing expected", bus.adr, bus.dat);
        end else begin
          e = exp_q.pop_front();
          check("beat_adr", bus.adr, e.adr);
          check("beat_dat", bus.dat, e.dat);
        end
        beat_idx++;
        if (beat_idx == 3) begin
          beat_idx = 0;
          occ--;
        end
      end
      if (we) begin
        if (accept) begin
          occ++;
          for (int i = 0; i < 3; i++)
            exp_q.push_back('{adr: addr[WB_WIDTH-1:0] + WB_WIDTH'(i),
                              dat: data[ROW_WIDTH-1-i*WB_WIDTH -: WB_WIDTH]});
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    prev_hold = !rst && bus.stb && !bus.ack;
    prev_adr  = bus.adr;
    prev_dat  = bus.dat;
  end

  // Wishbone slave: hold off, fixed wait states, or random waits plus stray ACKs while idle.
  typedef enum {ACK_HOLD, ACK_FIXED, ACK_RAND} ack_mode_e;
  ack_mode_e ack_mode  = ACK_HOLD;
  int        ack_delay = 0;
  int        wcnt      = 0;
  int        cur_delay = 0;

  function automatic int pick_delay();
    return (ack_mode == ACK_RAND) ? int'($urandom_range(0, 3)) : ack_delay;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!bus.stb || ack_mode == ACK_HOLD) begin
      wcnt      = 0;
      cur_delay = pick_delay();
      bus.ack   = (ack_mode == ACK_RAND && !bus.stb) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end else begin
      if (bus.ack) begin
        wcnt      = 0;
        cur_delay = pick_delay();
      end
      bus.ack = (wcnt >= cur_delay);
      wcnt++;
    end
  end

  task automatic push_row(input logic [WB_WIDTH-1:0] base, input logic [ROW_WIDTH-1:0] d);
    @(posedge clk);
    #1;
    we   = 1'b1;
    addr = {$urandom, $urandom, base};
    data = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && idle;
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_idle"}, idle, 1'b1);
  endtask

  function automatic logic [ROW_WIDTH-1:0] rand_row();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    int  snap;
    bit  found;
    logic [WB_WIDTH-1:0] base_a, base_b;

    rst     = 1'b1;
    we      = 1'b0;
    addr    = '0;
    data    = '0;
    bus.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_adr", bus.adr, 0);
    check("rst_dat", bus.dat, 0);
    check("rst_stb_cyc_we", {bus.stb, bus.cyc, bus.we}, 3'b000);
    check("rst_full", full, 1'b0);
    check("rst_overflow", ovf, 1'b0);
    check("rst_idle", idle, 1'b1);

    // Single row, zero-wait ACK: latency, CYC length, idle afterwards.
    ack_mode  = ACK_FIXED;
    ack_delay = 0;
    push_row(32'h100, {32'hA, 32'hB, 32'hC});
    @(negedge clk);
    check("t1_stb_cycle_n1", bus.stb, 1'b0);
    @(negedge clk);
    check("t1_stb_cycle_n2", bus.stb, 1'b1);
    check("t1_first_adr", bus.adr, 32'h100);
    check("t1_first_dat", bus.dat, 32'hA);
    c = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.cyc) break;
      c++;
    end
    check("t1_cyc_cycles", c, 3);
    check("t1_idle_after", idle, 1'b1);

    // Wait states: three cycles of ACK delay per beat.
    ack_delay = 3;
    snap = beats_seen;
    push_row($urandom, rand_row());
    drain("t2", 100);
    check("t2_beats", beats_seen - snap, 3);

    // Fill with ACK held off: eight accepted, ninth dropped.
    ack_delay = 0;
    ack_mode  = ACK_HOLD;
    @(posedge clk);
    #1;
    we = 1'b1;
    for (int i = 0; i < 9; i++) begin
      addr = {$urandom, $urandom, $urandom};
      data = rand_row();
      @(posedge clk);
      #1;
    end
    we = 1'b0;
    @(negedge clk);
    check("t3_full", full, 1'b1);
    check("t3_overflow", ovf, 1'b1);
    check("t3_stb_stalled", bus.stb, 1'b1);
    snap     = beats_seen;
    ack_mode = ACK_FIXED;
    drain("t3", 300);
    check("t3_beats", beats_seen - snap, 24);
    check("t3_overflow_sticky", ovf, 1'b1);

    // Address wrap at the top of the space.
    push_row(32'hFFFF_FFFF, rand_row());
    drain("t4", 100);

    // Reset after the first ACK of a row.
    push_row($urandom, rand_row());
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = bus.stb && bus.ack;
    end
    check("t5_first_ack_seen", found, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_stb_cyc", {bus.stb, bus.cyc}, 2'b00);
    check("t5_idle", idle, 1'b1);
    check("t5_overflow_cleared", ovf, 1'b0);
    snap = beats_seen;
    repeat (10) @(negedge clk);
    check("t5_no_more_beats", beats_seen - snap, 0);

    // Push landing on the final ACK of the only row.
    base_a = $urandom;
    base_b = $urandom;
    push_row(base_a, rand_row());
    repeat (3) @(posedge clk);
    #1;
    we   = 1'b1;
    addr = {64'd0, base_b};
    data = rand_row();
    @(negedge clk);
    check("t6_final_ack", bus.stb && bus.ack, 1'b1);
    check("t6_final_adr", bus.adr, base_a + 32'd2);
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    check("t6_gap_stb", bus.stb, 1'b0);
    check("t6_gap_not_idle", idle, 1'b0);
    @(negedge clk);
    check("t6_next_stb", bus.stb, 1'b1);
    check("t6_next_adr", bus.adr, base_b);
    drain("t6", 100);

    // Random traffic with random waits and stray ACKs.
    ack_mode = ACK_RAND;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      we   = ($urandom_range(0, 2) == 0);
      addr = {$urandom, $urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom};
      data = rand_row();
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    drain("rand", 2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
